// File: rtl/vec_mem_arbiter.sv
// Arbitrates one synchronous-RAM port between instruction fetch, scalar MEM
// and multi-beat vector MEM accesses (priority vector > scalar > fetch).
module vec_mem_arbiter #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int VLEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [AW-1:0]      if_addr,
  output logic [DW-1:0]      if_rdata,
  output logic               if_ready,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [AW-1:0]      d_addr,
  input  logic [DW-1:0]      d_wdata,
  output logic [DW-1:0]      d_rdata,
  output logic               d_ready,
  input  logic               v_req,
  input  logic               v_we,
  input  logic [AW-1:0]      v_addr,
  input  logic [VLEN*DW-1:0] v_wdata,
  output logic [VLEN*DW-1:0] v_rdata,
  output logic               v_ready,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic               stall_mem
);

  localparam int CW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(VLEN - 1);

  typedef enum logic [2:0] {IDLE, F_RESP, D_RESP, V_ISSUE, V_DRAIN, V_DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   beat, beat_nxt;
  logic [DW-1:0]   lane_buf [VLEN];
  logic [DW-1:0]   wlane    [VLEN];
  logic            cap_en;
  logic [CW-1:0]   cap_idx;

  for (genvar g = 0; g < VLEN; g++) begin : g_lanes
    assign wlane[g]              = v_wdata[g*DW +: DW];
    assign v_rdata[g*DW +: DW]   = lane_buf[g];
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    v_ready   = 1'b0;
    cap_en    = 1'b0;
    cap_idx   = '0;

    unique case (state)
      IDLE: begin
        if (v_req) begin
          mem_en    = 1'b1;
          mem_we    = v_we;
          mem_addr  = v_addr;
          mem_wdata = wlane[0];
          beat_nxt  = (VLEN == 1) ? '0 : CW'(1);
          state_nxt = (VLEN == 1) ? V_DRAIN : V_ISSUE;
        end else if (d_req) begin
          mem_en    = 1'b1;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          state_nxt = D_RESP;
        end else if (if_req) begin
          mem_en    = 1'b1;
          mem_addr  = if_addr;
          state_nxt = F_RESP;
        end
      end
      F_RESP: begin
        if_ready  = 1'b1;
        state_nxt = IDLE;
      end
      D_RESP: begin
        d_ready   = 1'b1;
        state_nxt = IDLE;
      end
      V_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = v_we;
        mem_addr  = v_addr + (AW'(beat) << 2);
        mem_wdata = wlane[beat];
        // Read data arriving now belongs to the beat issued last cycle.
        cap_en    = ~v_we;
        cap_idx   = beat - 1'b1;
        if (beat == LAST_BEAT) begin
          beat_nxt  = '0;
          state_nxt = V_DRAIN;
        end else begin
          beat_nxt  = beat + 1'b1;
        end
      end
      V_DRAIN: begin
        cap_en    = ~v_we;
        cap_idx   = LAST_BEAT;
        state_nxt = V_DONE;
      end
      V_DONE: begin
        v_ready   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Reset suppresses grants and completions in the very cycle it is high.
    if (rst) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if_ready  = 1'b0;
      d_ready   = 1'b0;
      v_ready   = 1'b0;
      cap_en    = 1'b0;
    end
  end

  assign if_rdata  = if_ready ? mem_rdata : '0;
  assign d_rdata   = d_ready  ? mem_rdata : '0;
  assign stall_mem = (d_req & ~d_ready) | (v_req & ~v_ready);

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the small lane buffer is cleared on reset because its
  // contents are directly visible on v_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      for (int i = 0; i < VLEN; i++) lane_buf[i] <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      if (cap_en) lane_buf[cap_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Self-checking bench for vec_mem_arbiter: directed table, reset corner cases
// and randomized multi-requester rounds against a transaction-level model.
module tb_vec_mem_arbiter;
  localparam int AW = 32, DW = 32, VLEN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_req, d_req, d_we, v_req, v_we;
  logic [AW-1:0]    if_addr, d_addr, v_addr;
  logic [DW-1:0]    d_wdata;
  logic [127:0]     v_wdata;
  logic [DW-1:0]    if_rdata, d_rdata;
  logic             if_ready, d_ready, v_ready;
  logic [127:0]     v_rdata;
  logic             mem_en, mem_we, stall_mem;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;

  vec_mem_arbiter #(.AW(AW), .DW(DW), .VLEN(VLEN)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
    .v_rdata(v_rdata), .v_ready(v_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after the issue cycle.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[11:2]];
    end
  end

  // Reference memory keyed by full byte address.
  logic [31:0] mdl [logic [31:0]];
  function automatic logic [31:0] mdl_rd(input logic [31:0] a);
    return mdl.exists(a) ? mdl[a] : 32'h0;
  endfunction

  typedef struct {
    logic f, d, v, d_we, v_we;
    logic [31:0] fa, da, va, dw;
    logic [127:0] vw;
  } txn_t;

  typedef struct {
    txn_t t;
    logic [31:0] ef, ed;
    logic [127:0] ev;
  } vec_t;

  int n_vec = 0, n_bad = 0;
  logic [127:0] last_v = '0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ram[a[11:2]] = d;
    mdl[a] = d;
  endtask

  // Presents all requests of one transaction set in the same cycle and checks
  // the RAM-port schedule, stalls, ready pulses and data cycle by cycle.
  task automatic run_round(input txn_t t, output logic [31:0] got_f,
                           output logic [31:0] got_d, output logic [127:0] got_v);
    int fs, ds, fe, de, ve, s;
    logic [31:0] ef, ed, xa, xwd;
    logic [127:0] ev;
    logic pf, pd, pv, xf, xd, xv, xen, xwe;
    got_f = '0; got_d = '0; got_v = '0;
    ef = '0; ed = '0; ev = '0;
    fs = -10; ds = -10; fe = -10; de = -10; ve = -10; s = 0;
    if (t.v) begin
      ve = VLEN + 1;
      for (int i = 0; i < VLEN; i++) begin
        ev[i*32 +: 32] = mdl_rd(t.va + 32'(4*i));
        if (t.v_we) mdl[t.va + 32'(4*i)] = t.vw[i*32 +: 32];
      end
      s = VLEN + 2;
    end
    if (t.d) begin
      ds = s; de = s + 1; s += 2;
      if (t.d_we) mdl[t.da] = t.dw;
      else        ed = mdl_rd(t.da);
    end
    if (t.f) begin
      fs = s; fe = s + 1;
      ef = mdl_rd(t.fa);
    end

    @(posedge clk); #1;
    if_req = t.f; if_addr = t.fa;
    d_req = t.d; d_we = t.d_we; d_addr = t.da; d_wdata = t.dw;
    v_req = t.v; v_we = t.v_we; v_addr = t.va; v_wdata = t.vw;
    pf = t.f; pd = t.d; pv = t.v;

    for (int k = 0; k < 64 && (pf || pd || pv); k++) begin
      @(negedge clk);
      if (k == 0) check("v_rdata_hold", v_rdata, last_v);
      xen = 1'b0; xwe = 1'b0; xa = '0; xwd = '0;
      if (t.v && k < VLEN) begin
        xen = 1'b1; xwe = t.v_we; xa = t.va + 32'(4*k); xwd = t.vw[k*32 +: 32];
      end
      if (t.d && k == ds) begin xen = 1'b1; xwe = t.d_we; xa = t.da; xwd = t.dw; end
      if (t.f && k == fs) begin xen = 1'b1; xwe = 1'b0; xa = t.fa; end
      check("mem_en", mem_en, xen);
      if (xen) begin
        check("mem_addr", mem_addr, xa);
        check("mem_we", mem_we, xwe);
        if (xwe) check("mem_wdata", mem_wdata, xwd);
      end
      check("stall_mem", stall_mem, (pd && k != de) || (pv && k != ve));
      xf = pf && k == fe; xd = pd && k == de; xv = pv && k == ve;
      check("if_ready", if_ready, xf);
      check("d_ready", d_ready, xd);
      check("v_ready", v_ready, xv);
      if (xf) begin got_f = if_rdata; check("if_rdata", if_rdata, ef); pf = 1'b0; end
      if (xd) begin
        got_d = d_rdata;
        if (!t.d_we) check("d_rdata", d_rdata, ed);
        pd = 1'b0;
      end
      if (xv) begin
        got_v = v_rdata;
        if (!t.v_we) begin check("v_rdata", v_rdata, ev); last_v = ev; end
        pv = 1'b0;
      end
      @(posedge clk); #1;
      if (xf) if_req = 1'b0;
      if (xd) d_req = 1'b0;
      if (xv) v_req = 1'b0;
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    return ($urandom_range(0, 1) != 0 ? 32'hFFFFFF00 : 32'h0) | (32'($urandom_range(0, 63)) << 2);
  endfunction

  localparam logic [127:0] VW5 = 128'h44440004_33330003_22220002_11110001;
  localparam logic [127:0] VW7 = 128'hA3A30003_A2A20002_A1A10001_A0A00000;
  localparam logic [127:0] V4321 = 128'h00000004_00000003_00000002_00000001;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vec_t tbl [7];
    txn_t t;
    logic [31:0] gf, gd;
    logic [127:0] gv;

    for (int i = 0; i < 1024; i++) ram[i] = '0;
    preload(32'h100, 32'hDEADBEEF);
    preload(32'h200, 32'hCAFE0200);
    for (int i = 0; i < 4; i++) preload(32'h40 + 32'(4*i), 32'(i + 1));

    tbl[0] = '{'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0, 128'h0},
               32'hDEADBEEF, 32'h0, 128'h0};
    tbl[1] = '{'{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h200, 32'h0, 32'h0, 128'h0},
               32'hDEADBEEF, 32'hCAFE0200, 128'h0};
    tbl[2] = '{'{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h40, 32'h0, 128'h0},
               32'h0, 32'h0, V4321};
    tbl[3] = '{'{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h300, 32'h0, 32'h12345678, 128'h0},
               32'h12345678, 32'h0, 128'h0};
    tbl[4] = '{'{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h508, 32'h500, 32'h0, VW5},
               32'h0, 32'h33330003, 128'h0};
    tbl[5] = '{'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h50C, 32'h504, 32'h500, 32'h0, 128'h0},
               32'h44440004, 32'h22220002, VW5};
    tbl[6] = '{'{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'hFFFFFFF8, 32'h0, VW7},
               32'hA2A20002, 32'h0, 128'h0};

    // Reset with a vector request pending: nothing may be issued.
    rst = 1'b1;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; v_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; v_wdata = '0;
    v_req = 1'b1; v_addr = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_readys", {if_ready, d_ready, v_ready}, 3'b000);
    check("rst_v_rdata", v_rdata, 128'h0);
    @(posedge clk); #1; v_req = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_round(tbl[i].t, gf, gd, gv);
      if (tbl[i].t.f) check($sformatf("tbl%0d_if_rdata", i), gf, tbl[i].ef);
      if (tbl[i].t.d && !tbl[i].t.d_we) check($sformatf("tbl%0d_d_rdata", i), gd, tbl[i].ed);
      if (tbl[i].t.v && !tbl[i].t.v_we) check($sformatf("tbl%0d_v_rdata", i), gv, tbl[i].ev);
    end

    // Reset two cycles into a vector read; request stays held throughout.
    @(posedge clk); #1;
    v_req = 1'b1; v_we = 1'b0; v_addr = 32'h40;
    @(negedge clk); check("rv_grant", mem_en, 1'b1);
    @(posedge clk); #1;
    @(negedge clk); check("rv_t1_ready", v_ready, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check("rv_rst_en", mem_en, 1'b0);
    check("rv_rst_addr", mem_addr, 32'h0);
    check("rv_rst_ready", v_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rv_rst_lanes", v_rdata, 128'h0);
    check("rv_rst_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) check("rv_regrant_addr", {mem_en, mem_addr}, {1'b1, 32'h40});
      check("rv_v_ready", v_ready, k == 5);
      if (k == 5) check("rv_v_rdata", v_rdata, V4321);
      @(posedge clk); #1;
      if (k == 5) v_req = 1'b0;
    end
    last_v = V4321;

    for (int r = 0; r < 40; r++) begin
      t.f = 1'($urandom_range(0, 1));
      t.d = 1'($urandom_range(0, 1));
      t.v = 1'($urandom_range(0, 1));
      if (!(t.f || t.d || t.v)) t.f = 1'b1;
      t.d_we = 1'($urandom_range(0, 1));
      t.v_we = 1'($urandom_range(0, 1));
      t.fa = rnd_addr(); t.da = rnd_addr(); t.va = rnd_addr();
      t.dw = $urandom;
      t.vw = {$urandom, $urandom, $urandom, $urandom};
      run_round(t, gf, gd, gv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_arbiter.md
VEC_MEM_ARBITER -- requirements
Module: vec_mem_arbiter

Interface
REQ-001 Parameter AW, default 32, memory byte-address width.
REQ-002 Parameter DW, default 32, word width.
REQ-003 Parameter VLEN, default 4, vector lanes per vector access.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 if_req in 1 / if_addr in AW  fetch read request and address, held stable until if_ready.
REQ-007 if_rdata out DW / if_ready out 1  fetch data and one-cycle completion pulse.
REQ-008 d_req in 1 / d_we in 1 / d_addr in AW / d_wdata in DW  scalar MEM-stage access, held until d_ready.
REQ-009 d_rdata out DW / d_ready out 1  scalar read data and one-cycle completion pulse.
REQ-010 v_req in 1 / v_we in 1 / v_addr in AW / v_wdata in VLEN*DW  vector MEM-stage access, held until v_ready.
REQ-011 v_rdata out VLEN*DW / v_ready out 1  vector read data (lane i = bits [i*DW +: DW]) and one-cycle pulse.
REQ-012 mem_en out 1 / mem_we out 1 / mem_addr out AW / mem_wdata out DW  single shared synchronous-RAM port.
REQ-013 mem_rdata in DW  RAM read data, valid the cycle after the read-issue cycle.
REQ-014 stall_mem out 1  to the hazard unit: freeze pipeline through the MEM stage.

Function
REQ-015 FSM states SHALL be IDLE, F_RESP, D_RESP, V_ISSUE, V_DRAIN, V_DONE.
REQ-016 IDLE grant priority SHALL be v_req > d_req > if_req (older instruction first); no grant if none is requesting.
REQ-017 Grant in IDLE SHALL drive mem_en=1 and the requester's we/addr/wdata in that same cycle (issue cycle).
REQ-018 Fetch grant: IDLE -> F_RESP; in F_RESP if_ready=1, if_rdata=mem_rdata, next state IDLE.
REQ-019 Scalar grant: IDLE -> D_RESP; in D_RESP d_ready=1, d_rdata=mem_rdata (don't-care for writes), next state IDLE.
REQ-020 Vector grant: beat 0 issued in IDLE, beat counter set to 1, next state V_ISSUE.
REQ-021 V_ISSUE SHALL issue one beat per cycle, beat i at address v_addr + 4*i modulo 2^AW, mem_wdata = lane i of v_wdata.
REQ-022 Read data for beat i SHALL be captured into lane buffer i the cycle after beat i is issued.
REQ-023 After beat VLEN-1 issued, V_ISSUE -> V_DRAIN (captures final lane, mem_en=0) -> V_DONE.
REQ-024 In V_DONE v_ready=1, v_rdata = lane buffer (fully registered), next state IDLE; writes complete identically.
REQ-025 Latencies from grant cycle T: fetch/scalar ready at T+1; vector ready at T+VLEN+1.
REQ-026 No request SHALL be granted in any *_RESP/V_DONE cycle; the held request is not re-granted.
REQ-027 mem_en SHALL be 0 in F_RESP, D_RESP, V_DRAIN, V_DONE and in IDLE without grant.
REQ-028 stall_mem SHALL equal (d_req & ~d_ready) | (v_req & ~v_ready), combinational.
REQ-029 if_ready low SHALL be the fetch-stall indication; no separate fetch-stall output.
REQ-030 A request deasserted before grant SHALL be dropped; deassertion after grant is illegal.
REQ-031 Lane buffer SHALL hold its value outside vector reads; scalar/fetch traffic SHALL not modify it.

Reset
REQ-032 While rst=1: state IDLE, beat counter 0, lane buffer 0, all *_ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset mid-operation SHALL abort the access without a ready pulse; a still-held request restarts from beat 0 after rst falls.

Verification
REQ-034 Fetch only: if_req=1, if_addr=0x100, RAM[0x100]=0xDEADBEEF -> mem_en at T, if_ready=1 with if_rdata=0xDEADBEEF at T+1.
REQ-035 Simultaneous if_req and d_req read 0x200 -> d_ready at T+1, IDLE at T+2, fetch granted T+2, if_ready T+3; stall_mem=1 at T only.
REQ-036 Vector read v_addr=0x40, RAM words 1,2,3,4 -> mem_addr 0x40,0x44,0x48,0x4C on T..T+3; v_ready at T+5, lanes {4,3,2,1} high-to-low.
REQ-037 Vector write v_addr=0xFFFFFFF8 -> beats at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap), mem_we=1 each beat, v_ready at T+5.
REQ-038 rst=1 at T+2 of vector read, v_req held -> no v_ready, all outputs zero during reset, vector reissued from beat 0 and completes 5 cycles after regrant.
